// File: rtl/asic_tester_pkg.sv
// Shared sizing and FSM encoding for the BRAM vector readout path.
// VECTOR_READER_PREFETCH_EN raises the number of vectors allowed in flight from 1 to 2.
package asic_tester_pkg;

  localparam int RAM_WIDTH     = 32;
  localparam int RAM_ADDR_BITS = 13;
  localparam int WORDS_PER_VEC = 4;
  localparam int VEC_WIDTH     = RAM_WIDTH * WORDS_PER_VEC;
  localparam int NUM_VEC_BITS  = 11;

  // Vectors issued to the BRAM but not yet handed to the consumer.
`ifdef VECTOR_READER_PREFETCH_EN
  localparam int MAX_OUTSTANDING = 2;
`else
  localparam int MAX_OUTSTANDING = 1;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/bram_vec_assembler.sv
// Collects BRAM words into lanes of the output vector register.
// With VECTOR_READER_PREFETCH_EN a one-deep holding buffer absorbs a vector finished while the output is occupied.
module bram_vec_assembler #(
  parameter int RAM_WIDTH     = 32,
  parameter int WORDS_PER_VEC = 4,
  localparam int LANE_W = $clog2(WORDS_PER_VEC),
  localparam int VEC_W  = RAM_WIDTH * WORDS_PER_VEC
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cap_en,
  input  logic [LANE_W-1:0] cap_lane,
  input  logic [RAM_WIDTH-1:0] cap_word,
  input  logic              handshake,
  input  logic              out_valid,
  output logic [VEC_W-1:0]  vec_data,
  output logic              out_load
);

  logic [VEC_W-1:0] asm_reg;
  logic [VEC_W-1:0] asm_full;
  logic [VEC_W-1:0] vec_reg;
  logic             last_lane;
  logic             out_free;

  // asm_full is the partial vector with the word arriving this cycle already merged in.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_VEC; gi++) begin : g_lane
      assign asm_full[gi*RAM_WIDTH +: RAM_WIDTH] =
        (cap_en && (cap_lane == LANE_W'(gi))) ? cap_word : asm_reg[gi*RAM_WIDTH +: RAM_WIDTH];
    end
  endgenerate

  assign last_lane = cap_en && (cap_lane == LANE_W'(WORDS_PER_VEC - 1));
  assign out_free  = !out_valid || handshake;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      asm_reg <= '0;
    end else if (cap_en) begin
      asm_reg <= asm_full;
    end
  end

`ifdef VECTOR_READER_PREFETCH_EN
  logic [VEC_W-1:0] hold_reg;
  logic             hold_full_reg;
  logic             hold_out;
  logic             to_out;
  logic             to_hold;

  assign hold_out = handshake && hold_full_reg;
  assign to_out   = last_lane && out_free && !hold_full_reg;
  assign to_hold  = last_lane && !to_out;
  assign out_load = hold_out || to_out;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vec_reg       <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
    end else begin
      if (hold_out) begin
        vec_reg <= hold_reg;
      end else if (to_out) begin
        vec_reg <= asm_full;
      end
      if (to_hold) begin
        hold_reg      <= asm_full;
        hold_full_reg <= 1'b1;
      end else if (hold_out) begin
        hold_full_reg <= 1'b0;
      end
    end
  end
`else
  assign out_load = last_lane && out_free;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vec_reg <= '0;
    end else if (out_load) begin
      vec_reg <= asm_full;
    end
  end
`endif

  assign vec_data = vec_reg;

endmodule

// File: rtl/bram_vector_reader.sv
// Reads NUM_VEC consecutive 4-word vectors from BRAM starting at BASE_ADDR and presents them with a valid/ready handshake.
// Define VECTOR_READER_PREFETCH_EN to fetch the next vector while the current one is presented.
module bram_vector_reader #(
  parameter int RAM_WIDTH     = asic_tester_pkg::RAM_WIDTH,
  parameter int RAM_ADDR_BITS = asic_tester_pkg::RAM_ADDR_BITS,
  parameter int WORDS_PER_VEC = asic_tester_pkg::WORDS_PER_VEC
) (
  input  logic                                      CLK,
  input  logic                                      RST_N,
  input  logic                                      START,
  input  logic [RAM_ADDR_BITS-1:0]                  BASE_ADDR,
  input  logic [asic_tester_pkg::NUM_VEC_BITS-1:0]  NUM_VEC,
  output logic                                      RAM_EN,
  output logic [RAM_ADDR_BITS-1:0]                  RAM_ADDR,
  input  logic [RAM_WIDTH-1:0]                      RAM_DOUT,
  output logic [RAM_WIDTH*WORDS_PER_VEC-1:0]        VEC_DATA,
  output logic                                      VEC_VALID,
  input  logic                                      VEC_READY,
  output logic                                      BUSY,
  output logic                                      DONE
);
  import asic_tester_pkg::*;

  localparam int LANE_W = $clog2(WORDS_PER_VEC);

  rd_state_e                state_reg, state_next;
  logic [RAM_ADDR_BITS-1:0] addr_reg, addr_next;
  logic [NUM_VEC_BITS-1:0]  num_reg, num_next;
  logic [NUM_VEC_BITS-1:0]  started_reg, started_next;
  logic [NUM_VEC_BITS-1:0]  hs_cnt_reg, hs_cnt_next;
  logic [LANE_W-1:0]        lane_reg, lane_next;
  logic                     issue_reg, issue_next;
  logic                     cap_en_reg;
  logic [LANE_W-1:0]        cap_lane_reg;
  logic                     handshake;
  logic                     last_hs;
  logic                     can_start;
  logic                     out_load;

  assign handshake = (state_reg == PRESENT) && VEC_READY;
  assign last_hs   = handshake && (hs_cnt_reg == num_reg - 1'b1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    num_next     = num_reg;
    started_next = started_reg;
    hs_cnt_next  = hs_cnt_reg;
    lane_next    = lane_reg;
    issue_next   = issue_reg;

    if (handshake) begin
      hs_cnt_next = hs_cnt_reg + 1'b1;
    end
    // A new vector may begin issuing only while the vectors it would queue behind fit downstream.
    can_start = ((state_reg == FETCH) || (state_reg == PRESENT)) && (started_reg != num_reg) &&
                ((started_reg - hs_cnt_next) < NUM_VEC_BITS'(MAX_OUTSTANDING));

    case (state_reg)
      IDLE: begin
        if (START) begin
          addr_next   = BASE_ADDR;
          num_next    = NUM_VEC;
          hs_cnt_next = '0;
          lane_next   = '0;
          if (NUM_VEC == '0) begin
            state_next = FINISH;
          end else begin
            state_next   = FETCH;
            issue_next   = 1'b1;
            started_next = NUM_VEC_BITS'(1);
          end
        end
      end
      FETCH: begin
        if (out_load) state_next = PRESENT;
      end
      PRESENT: begin
        if (last_hs) begin
          state_next = FINISH;
        end else if (handshake && !out_load) begin
          state_next = FETCH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Vectors are contiguous, so the address simply advances by one per issued word.
    if (issue_reg) begin
      addr_next = addr_reg + 1'b1;
      lane_next = lane_reg + 1'b1;
      if (lane_reg == LANE_W'(WORDS_PER_VEC - 1)) begin
        issue_next = can_start;
        if (can_start) started_next = started_reg + 1'b1;
      end
    end else if (can_start) begin
      issue_next   = 1'b1;
      started_next = started_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_reg     <= '0;
      num_reg      <= '0;
      started_reg  <= '0;
      hs_cnt_reg   <= '0;
      lane_reg     <= '0;
      issue_reg    <= 1'b0;
      cap_en_reg   <= 1'b0;
      cap_lane_reg <= '0;
    end else begin
      addr_reg     <= addr_next;
      num_reg      <= num_next;
      started_reg  <= started_next;
      hs_cnt_reg   <= hs_cnt_next;
      lane_reg     <= lane_next;
      issue_reg    <= issue_next;
      cap_en_reg   <= issue_reg;
      cap_lane_reg <= lane_reg;
    end
  end

  bram_vec_assembler #(
    .RAM_WIDTH    (RAM_WIDTH),
    .WORDS_PER_VEC(WORDS_PER_VEC)
  ) u_assembler (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .cap_en   (cap_en_reg),
    .cap_lane (cap_lane_reg),
    .cap_word (RAM_DOUT),
    .handshake(handshake),
    .out_valid(VEC_VALID),
    .vec_data (VEC_DATA),
    .out_load (out_load)
  );

  assign RAM_EN    = issue_reg;
  assign RAM_ADDR  = addr_reg;
  assign VEC_VALID = (state_reg == PRESENT);
  assign BUSY      = (state_reg == FETCH) || (state_reg == PRESENT);
  assign DONE      = (state_reg == FINISH);

endmodule

// File: tb/tb_bram_vector_reader.sv
// Bench for bram_vector_reader: BRAM model with registered read, expected vectors computed
// from base + 4k + i over the memory image, directed corner cases followed by random readouts.
module tb_bram_vector_reader;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b1;
  logic         START = 1'b0;
  logic [12:0]  BASE_ADDR = '0;
  logic [10:0]  NUM_VEC = '0;
  logic         RAM_EN;
  logic [12:0]  RAM_ADDR;
  logic [31:0]  RAM_DOUT = '0;
  logic [127:0] VEC_DATA;
  logic         VEC_VALID;
  logic         VEC_READY = 1'b0;
  logic         BUSY;
  logic         DONE;

  logic [31:0] mem [0:8191];
  int checks_total = 0;
  int checks_passed = 0;
  int cyc = 0;
  int ram_en_cnt = 0;
  int en_present_cnt = 0;
  int done_cnt = 0;

  bram_vector_reader dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .BASE_ADDR(BASE_ADDR),
    .NUM_VEC  (NUM_VEC),
    .RAM_EN   (RAM_EN),
    .RAM_ADDR (RAM_ADDR),
    .RAM_DOUT (RAM_DOUT),
    .VEC_DATA (VEC_DATA),
    .VEC_VALID(VEC_VALID),
    .VEC_READY(VEC_READY),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RAM_EN) RAM_DOUT <= mem[RAM_ADDR];
    if (RAM_EN) ram_en_cnt <= ram_en_cnt + 1;
    if (RAM_EN && VEC_VALID) en_present_cnt <= en_present_cnt + 1;
    if (DONE) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_total++;
    assert (got === exp) checks_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic logic [127:0] model_vec(input logic [12:0] base, input int k);
    logic [127:0] v;
    logic [12:0]  a;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      a = base + 13'(4 * k + i);
      v[32*i +: 32] = mem[a];
    end
    return v;
  endfunction

  task automatic readout(input logic [12:0] base, input int num, input int stall, input bit poke_start);
    int en0, pres0, done0, hs_cyc, exp_t, to;
    logic [127:0] held;
    bit stable;
    en0 = ram_en_cnt;
    pres0 = en_present_cnt;
    done0 = done_cnt;
    BASE_ADDR = base;
    NUM_VEC = 11'(num);
    VEC_READY = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
    cyc = 0;
    hs_cyc = 0;
    check("busy_after_start", BUSY, (num != 0));
    for (int k = 0; k < num; k++) begin
      VEC_READY = (stall == 0);
      to = 0;
      while (VEC_VALID !== 1'b1 && to < 64) begin
        step();
        to++;
      end
      check("vec_valid", VEC_VALID, 1'b1);
`ifdef VECTOR_READER_PREFETCH_EN
      if (stall == 0) begin
        exp_t = 5 + 4 * k;
        check("valid_time", cyc, exp_t);
      end
`else
      exp_t = (k == 0) ? 5 : hs_cyc + 5;
      check("valid_time", cyc, exp_t);
`endif
      check("vec_data", VEC_DATA, model_vec(base, k));
      held = VEC_DATA;
      stable = 1'b1;
      for (int s = 0; s < stall; s++) begin
        VEC_READY = 1'b0;
        if (poke_start && s == 2) begin
          START = 1'b1;
          BASE_ADDR = ~base;
          NUM_VEC = 11'd5;
        end
        step();
        START = 1'b0;
        if (VEC_VALID !== 1'b1 || VEC_DATA !== held) stable = 1'b0;
      end
      if (stall > 0) check("stall_stable", stable, 1'b1);
      VEC_READY = 1'b1;
      step();
      hs_cyc = cyc;
      VEC_READY = 1'b0;
    end
    check("done_pulse", {DONE, BUSY}, 2'b10);
    step();
    check("done_cleared", {DONE, BUSY, VEC_VALID}, 3'b000);
    check("done_count", done_cnt - done0, 1);
    check("ram_en_cycles", ram_en_cnt - en0, 4 * num);
`ifndef VECTOR_READER_PREFETCH_EN
    check("ram_en_in_present", en_present_cnt - pres0, 0);
`endif
    $display("readout base=%h num=%0d stall=%0d finished at cycle %0d", base, num, stall, cyc);
  endtask

  initial begin
    int to;
    int done0;
    for (int n = 0; n < 8192; n++) mem[n] = 32'(n);

    #2 RST_N = 1'b0;
    #1;
    check("reset_vec_data", VEC_DATA, '0);
    check("reset_ctrl", {RAM_EN, RAM_ADDR, VEC_VALID, BUSY, DONE}, '0);
    step();
    step();
    RST_N = 1'b1;
    step();

    readout(13'h0000, 1, 0, 1'b0);
    readout(13'h1FFE, 1, 0, 1'b0);
    readout(13'h0100, 3, 10, 1'b1);
    readout(13'h0555, 0, 0, 1'b0);

    // Reset while the second of four vectors is being fetched.
    BASE_ADDR = 13'h0040;
    NUM_VEC = 11'd4;
    VEC_READY = 1'b1;
    START = 1'b1;
    step();
    START = 1'b0;
    to = 0;
    while (VEC_VALID !== 1'b1 && to < 64) begin
      step();
      to++;
    end
    step();
    step();
    step();
    check("rst_precondition_ram_en", RAM_EN, 1'b1);
    done0 = done_cnt;
    #2 RST_N = 1'b0;
    #1;
    check("rst_mid_vec_data", VEC_DATA, '0);
    check("rst_mid_ctrl", {RAM_EN, RAM_ADDR, VEC_VALID, BUSY, DONE}, '0);
    VEC_READY = 1'b0;
    step();
    step();
    step();
    check("rst_no_done", done_cnt - done0, 0);
    RST_N = 1'b1;
    step();
    $display("reset mid-readout applied and released at cycle %0d", cyc);
    readout(13'h0123, 2, 0, 1'b0);

    readout(13'h0008, 8, 0, 1'b0);

    for (int n = 0; n < 8192; n++) mem[n] = $urandom();
    for (int t = 0; t < 6; t++) begin
      readout(13'($urandom_range(0, 8191)), int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 1'b0);
    end
    readout(13'h1FF0, 2047, 0, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
